// File: rtl/curve_coeff_loader_pkg.sv
// Shared definitions for the curve coefficient loader: controller state
// encoding, curve point count and the index width that addresses it.
package curve_coeff_loader_pkg;

  // Number of points in one curve (C00..C15 of the piecewise-linear transform)
  localparam int NPTS  = 16;
  // Width of the point index inside a burst
  localparam int IDX_W = 4;
  // Index of the final point of a burst
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NPTS - 1);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_COMMIT = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  // A burst is malformed when wr_last does not coincide with the last index:
  // either it ends early (last at idx<15) or runs past 16 words (no last at 15).
  function automatic logic burst_len_bad(input logic [IDX_W-1:0] idx,
                                         input logic             last);
    return (idx == IDX_LAST) != last;
  endfunction

endpackage

// File: rtl/curve_coeff_loader_timeout.sv
// Calibration timeout counter. start arms it at zero, it then counts one per
// cycle and holds at TMO with expire asserted until clear (or reset) disarms it.
module cal_timeout_cnt #(
  parameter int TMO = 64
) (
  input  logic clock,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic expire
);

  localparam int CW = $clog2(TMO + 1);

  logic [CW-1:0] r_cnt;
  logic          r_run;

  assign expire = r_run && (r_cnt == CW'(TMO));

  // Arm on start, disarm on clear, count while armed and not yet expired
  always_ff @(posedge clock) begin
    if (rst || clear) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (start) begin
      r_cnt <= '0;
      r_run <= 1'b1;
    end else if (r_run && !expire) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/curve_coeff_loader.sv
// Double-buffered loader for the 16 points of a piecewise-linear curve.
// Words stream into a shadow buffer; only a correctly framed 16-word burst is
// committed to coef_bus, after which the downstream delta table is asked to
// recompute (cal_begin) and table_ready is raised once it reports cal_valid.
module curve_coeff_loader
  import curve_coeff_loader_pkg::*;
#(
  parameter int DSIZE = 12,
  parameter int TMO   = 64
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DSIZE-1:0]      wr_data,
  input  logic                  wr_last,
  output logic [NPTS*DSIZE-1:0] coef_bus,
  output logic                  cal_begin,
  input  logic                  cal_valid,
  output logic                  table_ready,
  output logic                  err_len,
  output logic                  err_tmo
);

  state_t                r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [DSIZE-1:0]      r_shadow [NPTS];
  logic [NPTS*DSIZE-1:0] r_coef;
  logic                  r_cal_begin;
  logic                  r_table_ready;
  logic                  r_err_len;
  logic                  r_err_tmo;

  logic                  w_accept;
  logic                  w_tmo_start;
  logic                  w_tmo_clear;
  logic                  w_tmo_expire;

  // Ready is a pure decode of the state register, so no input reaches it
  assign wr_ready    = (r_state == S_LOAD);
  assign w_accept    = wr_valid && (r_state == S_LOAD);

  assign coef_bus    = r_coef;
  assign cal_begin   = r_cal_begin;
  assign table_ready = r_table_ready;
  assign err_len     = r_err_len;
  assign err_tmo     = r_err_tmo;

  // The counter is armed in the commit cycle so its count is zero in the
  // cycle cal_begin is high; it is disarmed whenever the wait ends.
  assign w_tmo_start = (r_state == S_COMMIT);
  assign w_tmo_clear = (r_state == S_WAIT) && (cal_valid || w_tmo_expire);

  cal_timeout_cnt #(
    .TMO (TMO)
  ) u_tmo (
    .clock  (clock),
    .rst    (rst),
    .start  (w_tmo_start),
    .clear  (w_tmo_clear),
    .expire (w_tmo_expire)
  );

  // Shadow buffer: every accepted word lands at the current index; a
  // malformed burst only dirties the shadow, never the active points.
  always_ff @(posedge clock) begin
    if (rst) begin
      for (int i = 0; i < NPTS; i++) begin
        r_shadow[i] <= '0;
      end
    end else if (w_accept) begin
      r_shadow[r_idx] <= wr_data;
    end
  end

  // Controller: burst framing, commit of shadow to active, calibration wait
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state       <= S_LOAD;
      r_idx         <= '0;
      r_coef        <= '0;
      r_table_ready <= 1'b0;
      r_cal_begin   <= 1'b0;
      r_err_len     <= 1'b0;
      r_err_tmo     <= 1'b0;
    end else begin
      r_cal_begin <= 1'b0;
      r_err_len   <= 1'b0;
      r_err_tmo   <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (w_accept) begin
            if (burst_len_bad(r_idx, wr_last)) begin
              r_err_len <= 1'b1;
              r_idx     <= '0;
            end else if (wr_last) begin
              r_idx   <= '0;
              r_state <= S_COMMIT;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        S_COMMIT: begin
          for (int n = 0; n < NPTS; n++) begin
            r_coef[n*DSIZE +: DSIZE] <= r_shadow[n];
          end
          r_table_ready <= 1'b0;
          r_cal_begin   <= 1'b1;
          r_state       <= S_WAIT;
        end
        S_WAIT: begin
          // A cal_valid arriving in the expiry cycle still completes the table
          if (cal_valid) begin
            r_table_ready <= 1'b1;
            r_state       <= S_LOAD;
          end else if (w_tmo_expire) begin
            r_err_tmo <= 1'b1;
            r_state   <= S_LOAD;
          end
        end
        default: begin
          r_state <= S_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_curve_coeff_loader.sv
// Self-checking bench for curve_coeff_loader with a behavioural model of the
// active points and table_ready flag.
module tb_curve_coeff_loader;

  localparam int DSIZE = 12;
  localparam int TMO   = 64;
  localparam int NP    = 16;
  // cal_begin is seen one edge after the edge that accepts the last word
  // (accept cycle, commit cycle, then the cal_begin cycle)
  localparam int CALBEGIN_LAT = 1;

  logic                  clock = 1'b0;
  logic                  rst;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DSIZE-1:0]      wr_data;
  logic                  wr_last;
  logic [NP*DSIZE-1:0]   coef_bus;
  logic                  cal_begin;
  logic                  cal_valid;
  logic                  table_ready;
  logic                  err_len;
  logic                  err_tmo;

  int total = 0;
  int bad   = 0;

  logic [DSIZE-1:0] stim    [NP];
  logic [DSIZE-1:0] exp_pts [NP];
  logic             exp_ready;

  always #5 clock = ~clock;

  curve_coeff_loader #(.DSIZE(DSIZE), .TMO(TMO)) dut (
    .clock       (clock),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .wr_last     (wr_last),
    .coef_bus    (coef_bus),
    .cal_begin   (cal_begin),
    .cal_valid   (cal_valid),
    .table_ready (table_ready),
    .err_len     (err_len),
    .err_tmo     (err_tmo)
  );

  function automatic logic [NP*DSIZE-1:0] exp_bus();
    logic [NP*DSIZE-1:0] v;
    v = '0;
    for (int n = 0; n < NP; n++) v[n*DSIZE +: DSIZE] = exp_pts[n];
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_commit();
    for (int n = 0; n < NP; n++) exp_pts[n] = stim[n];
    exp_ready = 1'b0;
  endtask

  task automatic model_reset();
    for (int n = 0; n < NP; n++) exp_pts[n] = '0;
    exp_ready = 1'b0;
  endtask

  task automatic fill_random();
    for (int n = 0; n < NP; n++) stim[n] = DSIZE'($urandom);
  endtask

  task automatic fill_ramp();
    for (int n = 0; n < NP; n++) stim[n] = DSIZE'(16 * n);
  endtask

  // Send n words of stim; wr_last on word index last_at (-1: never).
  // gap idle cycles with wr_valid low precede every word.
  task automatic send(input int n, input int last_at, input int gap);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b0;
      wr_last  = 1'b0;
      repeat (gap) tick();
      wr_valid = 1'b1;
      wr_data  = stim[i];
      wr_last  = (i == last_at);
      tick();
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  // Edges until cal_begin is seen, -1 if not within the bound
  task automatic wait_cal_begin(output int lat);
    lat = -1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (cal_begin === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    model_reset();
    if (coef_bus !== exp_bus()) begin bad++; $display("FAIL reset_coef got=%0h want=%0h", coef_bus, exp_bus()); end
    total++;
    if (table_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b want=0", table_ready); end
    total++;
    if ({cal_begin, err_len, err_tmo} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%0b want=000", {cal_begin, err_len, err_tmo}); end
    total++;
    rst = 1'b0;
    tick();
    if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%0b want=1", wr_ready); end
    total++;
  endtask

  task automatic test_ramp_commit();
    int lat, extra, rdy;
    fill_ramp();
    send(NP, NP - 1, 0);
    if (wr_ready !== 1'b0) begin bad++; $display("FAIL ramp_commit_ready got=%0b want=0", wr_ready); end
    total++;
    wait_cal_begin(lat);
    if (lat != CALBEGIN_LAT) begin bad++; $display("FAIL ramp_calbegin_lat got=%0d want=%0d", lat, CALBEGIN_LAT); end
    total++;
    model_commit();
    if (coef_bus !== exp_bus()) begin bad++; $display("FAIL ramp_coef got=%0h want=%0h", coef_bus, exp_bus()); end
    total++;
    if (table_ready !== exp_ready) begin bad++; $display("FAIL ramp_ready_low got=%0b want=%0b", table_ready, exp_ready); end
    total++;
    extra = 0;
    rdy   = 0;
    repeat (9) begin
      tick();
      if (cal_begin === 1'b1) extra++;
      if (wr_ready !== 1'b0) rdy++;
    end
    if (extra != 0) begin bad++; $display("FAIL ramp_calbegin_once got=%0d extra want=0", extra); end
    total++;
    if (rdy != 0) begin bad++; $display("FAIL ramp_wait_ready got=%0d cycles high want=0", rdy); end
    total++;
    cal_valid = 1'b1;
    tick();
    cal_valid = 1'b0;
    exp_ready = 1'b1;
    if (table_ready !== exp_ready) begin bad++; $display("FAIL ramp_table_ready got=%0b want=%0b", table_ready, exp_ready); end
    total++;
    if (wr_ready !== 1'b1) begin bad++; $display("FAIL ramp_back_to_load got=%0b want=1", wr_ready); end
    total++;
  endtask

  task automatic test_len_err();
    int lat;
    fill_random();
    send(10, 9, 0);
    if (err_len !== 1'b1) begin bad++; $display("FAIL short_err_len got=%0b want=1", err_len); end
    total++;
    if (coef_bus !== exp_bus()) begin bad++; $display("FAIL short_coef_kept got=%0h want=%0h", coef_bus, exp_bus()); end
    total++;
    if (table_ready !== exp_ready) begin bad++; $display("FAIL short_ready_kept got=%0b want=%0b", table_ready, exp_ready); end
    total++;
    tick();
    if (err_len !== 1'b0) begin bad++; $display("FAIL short_err_pulse got=%0b want=0", err_len); end
    total++;
    send(NP, -1, 0);
    if (err_len !== 1'b1) begin bad++; $display("FAIL long_err_len got=%0b want=1", err_len); end
    total++;
    if (coef_bus !== exp_bus()) begin bad++; $display("FAIL long_coef_kept got=%0h want=%0h", coef_bus, exp_bus()); end
    total++;
    fill_random();
    send(NP, NP - 1, 0);
    wait_cal_begin(lat);
    if (lat != CALBEGIN_LAT) begin bad++; $display("FAIL recover_calbegin_lat got=%0d want=%0d", lat, CALBEGIN_LAT); end
    total++;
    model_commit();
    if (coef_bus !== exp_bus()) begin bad++; $display("FAIL recover_coef got=%0h want=%0h", coef_bus, exp_bus()); end
    total++;
    cal_valid = 1'b1;
    tick();
    cal_valid = 1'b0;
    exp_ready = 1'b1;
    if (table_ready !== exp_ready) begin bad++; $display("FAIL recover_ready got=%0b want=%0b", table_ready, exp_ready); end
    total++;
  endtask

  task automatic test_timeout();
    int lat, n, rdy;
    fill_random();
    send(NP, NP - 1, 0);
    wait_cal_begin(lat);
    model_commit();
    if (coef_bus !== exp_bus()) begin bad++; $display("FAIL tmo_coef got=%0h want=%0h", coef_bus, exp_bus()); end
    total++;
    n   = 0;
    rdy = 0;
    while (n < 4 * TMO) begin
      tick();
      n++;
      if (err_tmo === 1'b1) break;
      if (wr_ready !== 1'b0) rdy++;
    end
    if (n != TMO + 1) begin bad++; $display("FAIL tmo_latency got=%0d want=%0d", n, TMO + 1); end
    total++;
    if (rdy != 0) begin bad++; $display("FAIL tmo_wait_ready got=%0d cycles high want=0", rdy); end
    total++;
    if (table_ready !== exp_ready) begin bad++; $display("FAIL tmo_ready_low got=%0b want=%0b", table_ready, exp_ready); end
    total++;
    if (wr_ready !== 1'b1) begin bad++; $display("FAIL tmo_back_to_load got=%0b want=1", wr_ready); end
    total++;
    tick();
    if (err_tmo !== 1'b0) begin bad++; $display("FAIL tmo_pulse_width got=%0b want=0", err_tmo); end
    total++;
  endtask

  task automatic test_tie_cal_wins();
    int lat, seen;
    fill_random();
    send(NP, NP - 1, 0);
    wait_cal_begin(lat);
    model_commit();
    // Advance to the cycle in which the counter has just reached TMO
    repeat (TMO) tick();
    cal_valid = 1'b1;
    tick();
    cal_valid = 1'b0;
    seen = (err_tmo === 1'b1) ? 1 : 0;
    repeat (3) begin
      tick();
      if (err_tmo === 1'b1) seen++;
    end
    exp_ready = 1'b1;
    if (seen != 0) begin bad++; $display("FAIL tie_no_err_tmo got=%0d pulses want=0", seen); end
    total++;
    if (table_ready !== exp_ready) begin bad++; $display("FAIL tie_ready got=%0b want=%0b", table_ready, exp_ready); end
    total++;
  endtask

  task automatic test_throttled();
    int lat;
    fill_ramp();
    send(NP, NP - 1, 1);
    if (wr_ready !== 1'b0) begin bad++; $display("FAIL thr_commit_ready got=%0b want=0", wr_ready); end
    total++;
    wait_cal_begin(lat);
    if (lat != CALBEGIN_LAT) begin bad++; $display("FAIL thr_calbegin_lat got=%0d want=%0d", lat, CALBEGIN_LAT); end
    total++;
    model_commit();
    if (coef_bus !== exp_bus()) begin bad++; $display("FAIL thr_coef got=%0h want=%0h", coef_bus, exp_bus()); end
    total++;
    cal_valid = 1'b1;
    tick();
    cal_valid = 1'b0;
    exp_ready = 1'b1;
    if (table_ready !== exp_ready) begin bad++; $display("FAIL thr_ready got=%0b want=%0b", table_ready, exp_ready); end
    total++;
  endtask

  task automatic test_ignored_cal_valid();
    int lat, hi;
    cal_valid = 1'b1;
    repeat (3) tick();
    cal_valid = 1'b0;
    if ({table_ready, cal_begin, wr_ready} !== {exp_ready, 1'b0, 1'b1}) begin
      bad++; $display("FAIL idle_cal_valid got=%0b want=%0b", {table_ready, cal_begin, wr_ready}, {exp_ready, 1'b0, 1'b1});
    end
    total++;
    fill_random();
    send(NP, NP - 1, 0);
    // Now in the commit cycle: a cal_valid here must not complete the table
    cal_valid = 1'b1;
    tick();
    cal_valid = 1'b0;
    model_commit();
    hi = (table_ready !== 1'b0) ? 1 : 0;
    repeat (5) begin
      tick();
      if (table_ready !== 1'b0) hi++;
    end
    if (hi != 0) begin bad++; $display("FAIL commit_cal_valid_ignored got=%0d cycles ready want=0", hi); end
    total++;
    cal_valid = 1'b1;
    tick();
    cal_valid = 1'b0;
    exp_ready = 1'b1;
    if (table_ready !== exp_ready) begin bad++; $display("FAIL late_cal_valid got=%0b want=%0b", table_ready, exp_ready); end
    total++;
  endtask

  task automatic test_rst_mid();
    int lat, pulses;
    fill_random();
    send(8, -1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    if (coef_bus !== exp_bus()) begin bad++; $display("FAIL rstmid_coef got=%0h want=%0h", coef_bus, exp_bus()); end
    total++;
    if ({table_ready, cal_begin, err_len, err_tmo, wr_ready} !== 5'b00001) begin
      bad++; $display("FAIL rstmid_outputs got=%0b want=00001", {table_ready, cal_begin, err_len, err_tmo, wr_ready});
    end
    total++;
    fill_random();
    send(NP, NP - 1, 0);
    wait_cal_begin(lat);
    if (lat != CALBEGIN_LAT) begin bad++; $display("FAIL rstmid_calbegin_lat got=%0d want=%0d", lat, CALBEGIN_LAT); end
    total++;
    model_commit();
    if (coef_bus !== exp_bus()) begin bad++; $display("FAIL rstmid_coef_after got=%0h want=%0h", coef_bus, exp_bus()); end
    total++;
    // Reset while waiting for calibration drops it silently
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    pulses = 0;
    repeat (TMO + 16) begin
      tick();
      if (cal_begin === 1'b1 || err_len === 1'b1 || err_tmo === 1'b1) pulses++;
    end
    if (pulses != 0) begin bad++; $display("FAIL rstwait_pulses got=%0d want=0", pulses); end
    total++;
    if ({coef_bus, table_ready, wr_ready} !== {exp_bus(), 1'b0, 1'b1}) begin
      bad++; $display("FAIL rstwait_state got=%0h want=%0h", {coef_bus, table_ready, wr_ready}, {exp_bus(), 1'b0, 1'b1});
    end
    total++;
  endtask

  initial begin
    rst       = 1'b1;
    wr_valid  = 1'b0;
    wr_data   = '0;
    wr_last   = 1'b0;
    cal_valid = 1'b0;
    model_reset();
    test_reset();
    test_ramp_commit();
    test_len_err();
    test_timeout();
    test_tie_cal_wins();
    test_throttled();
    test_ignored_cal_valid();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
